id_ex_hazard_ctrl: RTL and testbench
====================================

Name: id_ex_hazard_ctrl

Overview:
Pipeline hazard controller that drives the stall and flush controls of the IF/ID and ID/EX pipeline registers, i.e. the upstream producer of the ID/EX flush. It detects load-use hazards, taken-branch redirects and data-memory wait states. It sequences the required bubbles and freezes with a small FSM and keeps a stall-cycle counter. It sits beside the ID stage and observes the IF/ID, ID/EX and EX/MEM fields.

Parameters:
MEM_TIMEOUT, 15, max consecutive MWAIT cycles before err_timeout fires (1..255)
CNT_W, 16, width of stall_cycles counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
if_id_rs  in  5  rs field of instruction in IF/ID
if_id_rt  in  5  rt field of instruction in IF/ID
if_id_uses_rt  in  1  IF/ID instruction reads rt (R-type, store, branch)
id_ex_mem_read  in  1  M[1] (mem read) of the ID/EX stage
id_ex_rt  in  5  Instruction_20_16 of the ID/EX stage (load destination)
branch_taken  in  1  EX/MEM branch bit AND ALU zero; redirect this cycle
mem_req  in  1  MEM stage issues a load or store this cycle
mem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC may update at next edge
if_id_write  out  1  IF/ID may load at next edge
if_id_flush  out  1  IF/ID loads a NOP at next edge
id_ex_bubble  out  1  ID/EX loads all-zero EX/M/WB fields at next edge
ex_mem_flush  out  1  EX/MEM loads zero M/WB fields at next edge
pipe_freeze  out  1  every pipeline register holds its value at next edge
err_timeout  out  1  sticky; memory wait exceeded MEM_TIMEOUT
stall_cycles  out  CNT_W  count of cycles with pc_write=0

Behaviour:
- All outputs are synchronous-intent: they take effect at the next rising edge of clk. Control outputs are combinational from state and inputs. err_timeout and stall_cycles are registered.
- Reset (rst_n=0, asynchronous): state=RUN, wait_cnt=0, err_timeout=0, stall_cycles=0. While in reset: pc_write=1, if_id_write=1, all flush/bubble/freeze outputs=0.
- Hazard terms:
  - lu = id_ex_mem_read & (id_ex_rt!=0) & ((id_ex_rt==if_id_rs) | (if_id_uses_rt & id_ex_rt==if_id_rt))
  - mw = mem_req & ~mem_ready
- Priority when terms coincide: mw > branch_taken > lu.
- RUN:
  - mw: pipe_freeze=1, pc_write=0, if_id_write=0; next state MWAIT.
  - else branch_taken: if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1, pc_write=1 (PC takes the branch target); next state RUN. A simultaneous lu is discarded because the dependent instruction is squashed.
  - else lu: pc_write=0, if_id_write=0, id_ex_bubble=1; next state LDU.
  - else: all pass, next state RUN.
- LDU (exactly one cycle): all pass (the load has reached MEM and forwarding covers it); next state RUN. If mw is true in LDU, act as RUN with mw.
- MWAIT:
  - Freeze outputs stay asserted while mw=1; wait_cnt increments each cycle.
  - When mem_ready=1: freeze drops in that same cycle, wait_cnt clears, next state RUN.
  - When wait_cnt reaches MEM_TIMEOUT: set err_timeout (sticky until reset). The freeze continues; there is no forced release.
  - branch_taken is ignored in MWAIT; it is re-presented after the freeze.
- stall_cycles: increments on every edge where pc_write=0 and saturates at all-ones.
- Latency: detection and response occur in the same cycle; a load-use costs exactly 1 bubble; a taken branch costs 3 squashed slots.
- Reset asserted mid-MWAIT or mid-LDU: immediate return to RUN and clearing of the counters. There is no partial-state carryover.

Decomposition:
- The shared def.v gains the FSM state encodings (RUN=2'd0, LDU=2'd1, MWAIT=2'd2) and a NOP control constant (zero EX/M/WB).
- One natural sub-module, hazard_cmp: the purely combinational lu comparator, reusable by the forwarding unit.
- FSM, wait counter and stall counter stay in the top module.

Test Plan:
- lw $5 in ID/EX, add $6,$5,$7 in IF/ID -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle all pass; stall_cycles=1.
- lw $0 in ID/EX with rs=0 in IF/ID -> no stall; outputs stay at pass values.
- branch_taken=1 together with lu=1 -> if_id_flush=id_ex_bubble=ex_mem_flush=1, pc_write=1; state stays RUN; no LDU bubble follows.
- mem_req=1 with mem_ready low for 3 cycles -> pipe_freeze=1 for 3 cycles, released in the cycle mem_ready=1; stall_cycles=3; err_timeout=0.
- mem_ready held low for 20 cycles with MEM_TIMEOUT=15 -> err_timeout rises after cycle 15 and stays high after release; stall_cycles=20.
- rst_n pulsed low during MWAIT -> outputs immediately return to pass values, stall_cycles=0, state RUN.

Source files
------------

// File: rtl/id_ex_hazard_ctrl_pkg.sv
// Shared types and constants for the ID/EX hazard controller: FSM states,
// the pipeline-control bundle and the NOP control word.
package id_ex_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StLdu   = 2'd1,
    StMwait = 2'd2
  } state_e;

  // EX/M/WB control field loaded into ID/EX for a bubble
  localparam int unsigned     CtrlExMWbW = 9;
  localparam logic [8:0]      NopCtrl    = 9'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_flush;
    logic pipe_freeze;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CtrlPass = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                      id_ex_bubble: 1'b0, ex_mem_flush: 1'b0,
                                      pipe_freeze: 1'b0};
  localparam pipe_ctrl_t CtrlFreeze = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                        id_ex_bubble: 1'b0, ex_mem_flush: 1'b0,
                                        pipe_freeze: 1'b1};
  localparam pipe_ctrl_t CtrlBranch = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                        id_ex_bubble: 1'b1, ex_mem_flush: 1'b1,
                                        pipe_freeze: 1'b0};
  localparam pipe_ctrl_t CtrlLoadUse = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                         id_ex_bubble: 1'b1, ex_mem_flush: 1'b0,
                                         pipe_freeze: 1'b0};

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/id_ex_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller. The master modport is the
// controller (observes stage fields, drives controls); slave is the pipeline.
interface id_ex_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       if_id_rs;
  logic [4:0]       if_id_rt;
  logic             if_id_uses_rt;
  logic             id_ex_mem_read;
  logic [4:0]       id_ex_rt;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             ex_mem_flush;
  logic             pipe_freeze;
  logic             err_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    input  if_id_rs, if_id_rt, if_id_uses_rt, id_ex_mem_read, id_ex_rt,
    input  branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_freeze,
    output err_timeout, stall_cycles
  );

  modport slave (
    output if_id_rs, if_id_rt, if_id_uses_rt, id_ex_mem_read, id_ex_rt,
    output branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_freeze,
    input  err_timeout, stall_cycles
  );
endinterface

// File: rtl/id_ex_hazard_ctrl_hazard_cmp.sv
// Load-use comparator: a load in ID/EX writes a register the IF/ID instruction
// reads. Purely combinational so the forwarding unit can share it.
module id_ex_hazard_ctrl_hazard_cmp (
  input  logic [4:0] if_id_rs,
  input  logic [4:0] if_id_rt,
  input  logic       if_id_uses_rt,
  input  logic       id_ex_mem_read,
  input  logic [4:0] id_ex_rt,
  output logic       lu
);
  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit = (id_ex_rt == if_id_rs);
    rt_hit = if_id_uses_rt && (id_ex_rt == if_id_rt);
    // $0 is never a real dependency
    lu     = id_ex_mem_read && (id_ex_rt != 5'd0) && (rs_hit || rt_hit);
  end
endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// Hazard controller: load-use bubbles, branch squashes and memory-wait freezes
// sequenced by a three-state FSM, plus wait-timeout flag and stall counter.
module id_ex_hazard_ctrl
  import id_ex_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input logic                clk,
  input logic                rst_n,
  id_ex_hazard_ctrl_if.master bus
);
  localparam logic [7:0] TimeoutLim = 8'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  pipe_ctrl_t       ctrl;
  logic             lu;
  logic             mw;

  id_ex_hazard_ctrl_hazard_cmp u_hazard_cmp (
    .if_id_rs       (bus.if_id_rs),
    .if_id_rt       (bus.if_id_rt),
    .if_id_uses_rt  (bus.if_id_uses_rt),
    .id_ex_mem_read (bus.id_ex_mem_read),
    .id_ex_rt       (bus.id_ex_rt),
    .lu             (lu)
  );

  always_comb begin
    mw      = bus.mem_req && !bus.mem_ready;
    ctrl    = CtrlPass;
    state_d = state_q;
    wait_d  = 8'd0;
    unique case (state_q)
      StRun: begin
        if (mw) begin
          ctrl    = CtrlFreeze;
          state_d = StMwait;
          wait_d  = 8'd1;
        end else if (bus.branch_taken) begin
          // squashes the dependent instruction, so any load-use is moot
          ctrl    = CtrlBranch;
          state_d = StRun;
        end else if (lu) begin
          ctrl    = CtrlLoadUse;
          state_d = StLdu;
        end else begin
          state_d = StRun;
        end
      end
      StLdu: begin
        if (mw) begin
          ctrl    = CtrlFreeze;
          state_d = StMwait;
          wait_d  = 8'd1;
        end else begin
          state_d = StRun;
        end
      end
      StMwait: begin
        if (mw) begin
          ctrl    = CtrlFreeze;
          state_d = StMwait;
          wait_d  = sat_inc8(wait_q);
        end else begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase

    if (!rst_n) ctrl = CtrlPass;

    err_d   = err_q || (wait_d >= TimeoutLim);
    stall_d = stall_q;
    if (!ctrl.pc_write && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign bus.pc_write     = ctrl.pc_write;
  assign bus.if_id_write  = ctrl.if_id_write;
  assign bus.if_id_flush  = ctrl.if_id_flush;
  assign bus.id_ex_bubble = ctrl.id_ex_bubble;
  assign bus.ex_mem_flush = ctrl.ex_mem_flush;
  assign bus.pipe_freeze  = ctrl.pipe_freeze;
  assign bus.err_timeout  = err_q;
  assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Self-checking bench for id_ex_hazard_ctrl: directed scenarios plus random
// traffic against a cycle-level behavioural model.
module tb_id_ex_hazard_ctrl;
  localparam int unsigned MemTimeout = 15;
  localparam int unsigned CntW       = 16;
  localparam logic [5:0]  Pass       = 6'b110000;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   fails;

  id_ex_hazard_ctrl_if #(.CNT_W(CntW)) bus ();

  id_ex_hazard_ctrl #(.MEM_TIMEOUT(MemTimeout), .CNT_W(CntW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_freeze, err, stalls}
  logic [22:0] obs_all;
  assign obs_all = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble,
                    bus.ex_mem_flush, bus.pipe_freeze, bus.err_timeout, bus.stall_cycles};

  // Behavioural model: "waiting on memory", "bubble just inserted", wait length.
  bit         m_wait, m_ldu, m_err;
  int         m_len, m_stalls;
  bit         n_wait, n_ldu, n_err;
  int         n_len, n_stalls;
  logic [5:0] exp_ctrl;
  logic [22:0] exp_all;

  task automatic model_reset();
    m_wait = 0; m_ldu = 0; m_err = 0; m_len = 0; m_stalls = 0;
  endtask

  task automatic model_eval();
    bit lu, mw;
    lu = bus.id_ex_mem_read && (bus.id_ex_rt != 0) &&
         ((bus.id_ex_rt == bus.if_id_rs) || (bus.if_id_uses_rt && bus.id_ex_rt == bus.if_id_rt));
    mw = bus.mem_req && !bus.mem_ready;
    n_wait = 0; n_ldu = 0; n_len = 0; n_err = m_err; n_stalls = m_stalls;
    if (mw) begin
      exp_ctrl = 6'b000001;
      n_wait   = 1;
      n_len    = m_wait ? ((m_len < 255) ? m_len + 1 : 255) : 1;
      if (n_len >= MemTimeout) n_err = 1;
    end else if (m_wait || m_ldu) begin
      exp_ctrl = Pass;
    end else if (bus.branch_taken) begin
      exp_ctrl = 6'b111110;
    end else if (lu) begin
      exp_ctrl = 6'b000100;
      n_ldu    = 1;
    end else begin
      exp_ctrl = Pass;
    end
    if (!exp_ctrl[5] && m_stalls < 65535) n_stalls = m_stalls + 1;
    exp_all = {exp_ctrl, m_err, m_stalls[15:0]};
  endtask

  task automatic advance();
    @(posedge clk);
    m_wait = n_wait; m_ldu = n_ldu; m_len = n_len; m_err = n_err; m_stalls = n_stalls;
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                       input logic mrd, input logic [4:0] ex_rt, input logic br,
                       input logic req, input logic rdy);
    bus.if_id_rs = rs; bus.if_id_rt = rt; bus.if_id_uses_rt = uses_rt;
    bus.id_ex_mem_read = mrd; bus.id_ex_rt = ex_rt; bus.branch_taken = br;
    bus.mem_req = req; bus.mem_ready = rdy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (obs_all !== {Pass, 1'b0, 16'd0}) begin
        fails++;
        $display("FAIL reset[%0d]: got %h, want %h", i, obs_all, {Pass, 1'b0, 16'd0});
      end
    end
    @(posedge clk); #1;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_load_use();
    drive(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); model_eval();
      tests_run++;
      if (obs_all !== exp_all) begin
        fails++;
        $display("FAIL load_use[%0d]: got %h, want %h", i, obs_all, exp_all);
      end
      advance();
      drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    end
    tests_run++;
    if (bus.stall_cycles !== 16'd1) begin
      fails++;
      $display("FAIL load_use_stalls: got %0d, want 1", bus.stall_cycles);
    end
    // rt match only counts when the instruction actually reads rt
    drive(5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    @(negedge clk); model_eval();
    tests_run++;
    if (obs_all !== exp_all) begin
      fails++;
      $display("FAIL load_use_no_rt: got %h, want %h", obs_all, exp_all);
    end
    advance();
  endtask

  task automatic test_zero_reg();
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); model_eval();
    tests_run++;
    if (obs_all[22:17] !== Pass || obs_all !== exp_all) begin
      fails++;
      $display("FAIL zero_reg: got %h, want %h", obs_all, exp_all);
    end
    advance();
  endtask

  task automatic test_branch_lu();
    drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    @(negedge clk); model_eval();
    tests_run++;
    if (obs_all[22:17] !== 6'b111110 || obs_all !== exp_all) begin
      fails++;
      $display("FAIL branch_lu: got %h, want %h", obs_all, exp_all);
    end
    advance();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); model_eval();
    tests_run++;
    if (obs_all !== exp_all) begin
      fails++;
      $display("FAIL branch_no_ldu: got %h, want %h", obs_all, exp_all);
    end
    advance();
  endtask

  task automatic test_mem_wait(input int cycles, input string tag);
    int base;
    base = m_stalls;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i <= cycles; i++) begin
      if (i == cycles) bus.mem_ready = 1'b1;
      // branch must be ignored while frozen
      bus.branch_taken = (i == 1);
      @(negedge clk); model_eval();
      tests_run++;
      if (obs_all !== exp_all) begin
        fails++;
        $display("FAIL %s[%0d]: got %h, want %h", tag, i, obs_all, exp_all);
      end
      advance();
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (int'(bus.stall_cycles) != base + cycles) begin
      fails++;
      $display("FAIL %s_stalls: got %0d, want %0d", tag, bus.stall_cycles, base + cycles);
    end
    tests_run++;
    if (bus.err_timeout !== (cycles > MemTimeout - 1 || m_err)) begin
      fails++;
      $display("FAIL %s_err: got %b, want %b", tag, bus.err_timeout,
               (cycles > MemTimeout - 1 || m_err));
    end
  endtask

  task automatic test_reset_mid_wait();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); model_eval(); advance();
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (obs_all !== {Pass, 1'b0, 16'd0}) begin
      fails++;
      $display("FAIL reset_mid_wait: got %h, want %h", obs_all, {Pass, 1'b0, 16'd0});
    end
    model_reset();
    @(posedge clk); #1;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk); model_eval();
    tests_run++;
    if (obs_all !== exp_all) begin
      fails++;
      $display("FAIL after_reset_run: got %h, want %h", obs_all, exp_all);
    end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)));
      @(negedge clk); model_eval();
      tests_run++;
      if (obs_all !== exp_all) begin
        fails++;
        $display("FAIL random[%0d]: got %h, want %h", i, obs_all, exp_all);
      end
      advance();
    end
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    model_reset();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch_lu();
    test_mem_wait(3, "mem_wait3");
    test_mem_wait(20, "mem_timeout");
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
